bus_ram_slave: RTL and testbench
================================

# bus_ram_slave

Word-addressed RAM responder for the single-master memory bus that the memory controller drives toward the outside world (bus_en / wr_en / wr_data / addr / byte_en out, ack / rd_data back). It sits at the far end of that bus in simulation and FPGA tops, and is the target the dual-core system's external port talks to. It captures each request, inserts a programmable number of wait states, performs the byte-masked write or the word read, and returns a one-cycle ack. Out-of-range accesses are acknowledged with an error flag.

## Interface
- MEM_WORDS, 4096: RAM depth in 32-bit words; must be a power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be aligned to MEM_WORDS*4.
- LATENCY, 1: wait states inserted before ack; legal range 0..15.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_bus_en  in  1  request valid; the master holds it and all request fields stable until it sees o_ack.
- i_wr_en  in  1  1 = write, 0 = read.
- i_wr_data  in  32  write data, byte lanes selected by i_byte_en.
- i_addr  in  32  byte address; bits [1:0] ignored.
- i_byte_en  in  4  lane enables for writes; bit n covers bits [8n+7:8n]; ignored for reads.
- o_ack  out  1  one-cycle completion pulse.
- o_rd_data  out  32  read data; valid only while o_ack=1, 0 otherwise.
- o_err  out  1  asserted with o_ack when the access was out of range.

## Operation
- States: IDLE, WAIT, ACK.
- IDLE: if i_bus_en=1, latch wr_en, wr_data, word index, byte_en, and the range check into request registers. Load wait counter with LATENCY. Go to ACK if LATENCY=0, else go to WAIT.
- WAIT: decrement the counter each cycle. When the counter reaches 1, the next edge goes to ACK. i_bus_en is not sampled in WAIT. A request that has been captured always completes, even if the master drops i_bus_en.
- Array access happens on the edge that enters ACK, using the latched fields.
  - In-range write: update only the enabled bytes. byte_en=0000 is legal and writes nothing.
  - In-range read: register the word into o_rd_data.
- ACK: o_ack=1. o_err=1 if out of range. The next edge always goes to IDLE.
- Range check: in range iff (addr − BASE_ADDR) is in 0..MEM_WORDS*4−1, evaluated as unsigned 32-bit. The subtraction wraps, so addresses below BASE_ADDR are out of range.
- Out-of-range accesses: writes modify nothing, reads return 0, o_err=1.
- Writes return o_rd_data=0.
- Back-to-back: if i_bus_en is still high in the cycle after ACK, the responder treats it as a new request. The master must drop i_bus_en on the edge where it samples o_ack unless it intends a new transfer.
- Reset (i_rst=0, any time):
  - State goes to IDLE; o_ack=0, o_err=0, o_rd_data=0.
  - A pending request is discarded. A write that has not yet reached the ACK entry edge is not performed.
  - RAM contents are not cleared.

## Timing
- Request sampled at edge E0, in IDLE with i_bus_en=1.
- o_ack is high for exactly one cycle, starting at edge E0+1+LATENCY.
  - LATENCY=0: ack in the cycle right after the request cycle.
  - LATENCY=15: ack 16 cycles after sampling.
- Throughput: one transfer per LATENCY+2 cycles, counting the IDLE sample cycle.
- A write is visible to a read whose request is sampled at or after the edge leaving ACK.
- o_ack, o_err and o_rd_data are registered outputs with no combinational path from any input.

## Test plan
- Reset then idle: i_rst low for 3 cycles, then high with i_bus_en=0 for 10 cycles -> o_ack, o_err and o_rd_data remain 0 throughout.
- Write/read, LATENCY=1: write 32'hDEADBEEF to 0x10 with byte_en=1111, then read 0x10 -> each ack arrives exactly 2 cycles after its request edge, and the read returns 32'hDEADBEEF.
- Byte masking: preload 0x20 with 32'h11223344, write 32'hAABBCCDD with byte_en=0101, read 0x20 -> 32'h11BB33DD. Also write with byte_en=0000 -> the word is unchanged.
- Latency sweep: LATENCY=0 and LATENCY=15 -> ack in cycle E0+1 and E0+16 respectively. Hold i_bus_en high through ack to check the back-to-back case -> the second ack arrives LATENCY+2 cycles after the first.
- Out of range: MEM_WORDS=4096, BASE_ADDR=0. Write 32'h12345678 to 0x4000, then read 0x4000 -> both acked with o_err=1 and o_rd_data=0. Word 0 is unchanged, since the write did not alias.
- Reset mid-operation: LATENCY=8, write 32'hCAFEF00D to 0x8; assert i_rst at cycle 4 of WAIT, release, then read 0x8 -> no ack for the aborted write, and the read returns the prior contents of 0x8.

Source files
------------

// File: rtl/bus_ram_slave.sv
// bus_ram_slave: word-addressed RAM responder with programmable wait states,
// byte-masked writes and an error acknowledge for out-of-range accesses.
module bus_ram_slave #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned LATENCY   = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_bus_en,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_data,
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_byte_en,
    output logic        o_ack,
    output logic [31:0] o_rd_data,
    output logic        o_err
);
    localparam int AW = $clog2(MEM_WORDS);
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           wr_q, wr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [3:0]     be_q, be_d;
    logic           inr_q, inr_d;
    logic [31:0]    rd_q, rd_d;
    logic [31:0]    mem [MEM_WORDS];
    logic [31:0]    off;
    logic           in_rng;
    logic           mem_we;
    // Wrapping subtraction makes addresses below the base land far out of range.
    assign off    = i_addr - BASE_ADDR;
    assign in_rng = (off >> (AW + 2)) == 32'd0;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        be_d    = be_q;
        inr_d   = inr_q;
        case (state_q)
            IDLE: if (i_bus_en) begin
                wr_d    = i_wr_en;
                wdata_d = i_wr_data;
                idx_d   = off[AW+1:2];
                be_d    = i_byte_en;
                inr_d   = in_rng;
                cnt_d   = 4'(LATENCY);
                state_d = (LATENCY == 0) ? ACK : WAIT;
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? ACK : WAIT;
            end
            default: state_d = IDLE;
        endcase
        // ACK always leaves after one cycle, so state_d==ACK marks the entry edge only.
        mem_we = (state_d == ACK) && wr_d && inr_d;
        rd_d   = ((state_d == ACK) && !wr_d && inr_d) ? mem[idx_d] : 32'h0;
    end
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            idx_q   <= '0;
            be_q    <= '0;
            inr_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            inr_q   <= inr_d;
            rd_q    <= rd_d;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst && mem_we)
            for (int b = 0; b < 4; b++)
                if (be_d[b]) mem[idx_d][8*b +: 8] <= wdata_d[8*b +: 8];
    end
    assign o_ack     = (state_q == ACK);
    assign o_err     = o_ack && !inr_q;
    assign o_rd_data = rd_q;
endmodule

// File: tb/tb_bus_ram_slave.sv
// tb_bus_ram_slave: four responders with different latencies/bases driven by a
// bus master task and checked every cycle against a transaction-level model.
module tb_bus_ram_slave;
    localparam int unsigned LATS  [4] = '{0, 1, 8, 15};
    localparam logic [31:0] BASES [4] = '{32'h0, 32'h0, 32'h0, 32'h0001_0000};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic        bus_en [4];
    logic        wen    [4];
    logic [31:0] wdata  [4];
    logic [31:0] addr   [4];
    logic [3:0]  be     [4];
    logic        ack    [4];
    logic        err    [4];
    logic [31:0] rdd    [4];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;
    int          exp_cyc [4];
    logic        exp_err [4];
    logic [31:0] exp_rd  [4];
    logic [31:0] mm [4][4096];

    logic [31:0] rv;
    logic        ev;
    int          lt, gp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        bus_ram_slave #(.MEM_WORDS(4096), .BASE_ADDR(BASES[g]), .LATENCY(LATS[g])) dut (
            .i_clk(clk), .i_rst(rst_n), .i_bus_en(bus_en[g]), .i_wr_en(wen[g]),
            .i_wr_data(wdata[g]), .i_addr(addr[g]), .i_byte_en(be[g]),
            .o_ack(ack[g]), .o_rd_data(rdd[g]), .o_err(err[g]));
    end

    task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s inst%0d cycle %0d: got %h, want %h", nm, k, cyc, got, want);
        end
    endtask

    function automatic bit in_rng(input int k, input logic [31:0] a);
        return (a - BASES[k]) < 32'h4000;
    endfunction

    function automatic int widx(input int k, input logic [31:0] a);
        return int'(((a - BASES[k]) >> 2) & 32'hFFF);
    endfunction

    // Outputs must be zero except in the single cycle the model predicts an ack.
    always @(posedge clk) begin
        #2;
        if (chk_on)
            for (int k = 0; k < 4; k++) begin
                bit e;
                e = (cyc == exp_cyc[k]);
                chk("ack", k, 32'(ack[k]), 32'(e));
                chk("err", k, 32'(err[k]), 32'(e && exp_err[k]));
                chk("rd_data", k, rdd[k], e ? exp_rd[k] : 32'h0);
            end
    end

    task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input int nrep,
                        output logic [31:0] rdv, output logic errv, output int lat, output int gap);
        int t0, first;
        bit got;
        lat = -1; gap = -1; rdv = '0; errv = 1'b0; first = 0;
        @(negedge clk);
        bus_en[k] = 1'b1; wen[k] = wr; addr[k] = a; wdata[k] = d; be[k] = m;
        t0 = cyc;
        for (int r = 0; r < nrep; r++) begin
            exp_cyc[k] = cyc + ((r == 0) ? 1 : 2) + int'(LATS[k]);
            exp_err[k] = !in_rng(k, a);
            exp_rd[k]  = (!wr && in_rng(k, a)) ? mm[k][widx(k, a)] : 32'h0;
            got = 1'b0;
            for (int n = 0; n < 40 && !got; n++) begin
                @(negedge clk);
                got = ack[k];
            end
            if (!got) begin
                n_chk++;
                n_fail++;
                $display("FAIL ack_timeout inst%0d: got no ack, want ack at cycle %0d", k, exp_cyc[k]);
            end
            if (wr && in_rng(k, a))
                for (int b = 0; b < 4; b++)
                    if (m[b]) mm[k][widx(k, a)][8*b +: 8] = d[8*b +: 8];
            rdv = rdd[k];
            errv = err[k];
            if (r == 0) begin
                lat = cyc - t0;
                first = cyc;
            end else gap = cyc - first;
        end
        bus_en[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            bus_en[k] = 1'b0; wen[k] = 1'b0; wdata[k] = '0; addr[k] = '0; be[k] = '0;
            exp_cyc[k] = -1; exp_err[k] = 1'b0; exp_rd[k] = '0;
        end
        repeat (2) @(posedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        for (int k = 0; k < 4; k++)
            for (int w = 0; w < 8; w++)
                xfer(k, 1'b1, BASES[k] + 32'(w * 4), $urandom, 4'hF, 1, rv, ev, lt, gp);

        xfer(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1, rv, ev, lt, gp);
        chk("lat_wr_L1", 1, 32'(lt), 32'd2);
        chk("wr_rdata_zero", 1, rv, 32'h0);
        xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 1, rv, ev, lt, gp);
        chk("lat_rd_L1", 1, 32'(lt), 32'd2);
        chk("rd_deadbeef", 1, rv, 32'hDEADBEEF);

        xfer(1, 1'b1, 32'h20, 32'h11223344, 4'hF, 1, rv, ev, lt, gp);
        xfer(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1, rv, ev, lt, gp);
        xfer(1, 1'b0, 32'h20, 32'h0, 4'h0, 1, rv, ev, lt, gp);
        chk("byte_mask", 1, rv, 32'h11BB33DD);
        xfer(1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 1, rv, ev, lt, gp);
        xfer(1, 1'b0, 32'h20, 32'h0, 4'h0, 1, rv, ev, lt, gp);
        chk("byte_en_none", 1, rv, 32'h11BB33DD);

        xfer(0, 1'b1, 32'h40, 32'h5A5A0001, 4'hF, 2, rv, ev, lt, gp);
        chk("lat_L0", 0, 32'(lt), 32'd1);
        chk("b2b_gap_L0", 0, 32'(gp), 32'd2);
        xfer(3, 1'b0, 32'h0001_0010, 32'h0, 4'h0, 2, rv, ev, lt, gp);
        chk("lat_L15", 3, 32'(lt), 32'd16);
        chk("b2b_gap_L15", 3, 32'(gp), 32'd17);

        xfer(1, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 1, rv, ev, lt, gp);
        xfer(1, 1'b1, 32'h4000, 32'h12345678, 4'hF, 1, rv, ev, lt, gp);
        chk("oor_wr_err", 1, 32'(ev), 32'd1);
        xfer(1, 1'b0, 32'h4000, 32'h0, 4'h0, 1, rv, ev, lt, gp);
        chk("oor_rd_err", 1, 32'(ev), 32'd1);
        chk("oor_rd_zero", 1, rv, 32'h0);
        xfer(1, 1'b0, 32'h0, 32'h0, 4'h0, 1, rv, ev, lt, gp);
        chk("no_alias", 1, rv, 32'h0BADF00D);
        xfer(3, 1'b0, 32'h0000_FFFC, 32'h0, 4'h0, 1, rv, ev, lt, gp);
        chk("below_base_err", 3, 32'(ev), 32'd1);

        xfer(2, 1'b1, 32'h8, 32'h01020304, 4'hF, 1, rv, ev, lt, gp);
        @(negedge clk);
        bus_en[2] = 1'b1; wen[2] = 1'b1; addr[2] = 32'h8; wdata[2] = 32'hCAFEF00D; be[2] = 4'hF;
        exp_cyc[2] = -1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        bus_en[2] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        xfer(2, 1'b0, 32'h8, 32'h0, 4'h0, 1, rv, ev, lt, gp);
        chk("reset_abort", 2, rv, 32'h01020304);

        for (int i = 0; i < 80; i++) begin
            int k, w, sel;
            logic [31:0] a;
            k = $urandom_range(0, 3);
            w = $urandom_range(0, 7);
            sel = $urandom_range(0, 5);
            a = (sel == 0) ? BASES[k] + 32'h4000 + 32'(w * 4) :
                (sel == 1) ? BASES[k] - 32'd4 :
                             BASES[k] + 32'(w * 4) + 32'($urandom_range(0, 3));
            xfer(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), $urandom_range(1, 2),
                 rv, ev, lt, gp);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
